// File: rtl/fir_stream_driver.sv
// ============================================================================
// Module   : fir_stream_driver
// Purpose  : Stream-fed sequencer for the top_fir core: FIFO-buffers samples,
//            drives stf/xn, captures y on eof, returns results on a stream.
// Option   : SEQ_TIMEOUT_EN enables the WAIT-state abort after TIMEOUT cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_stream_driver #(
  parameter int DW         = 18,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          s_valid_i,
  input  logic [DW-1:0] s_data_i,
  output logic          s_ready_o,
  output logic          stf_o,
  output logic [DW-1:0] xn_o,
  input  logic [DW-1:0] y_i,
  input  logic          eof_i,
  output logic          m_valid_o,
  output logic [DW-1:0] m_data_o,
  input  logic          m_ready_i,
  output logic          busy_o,
  output logic [15:0]   count_o,
  output logic          timeout_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t        state;
  logic [DW-1:0] mem [FIFO_DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          push;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign push      = s_valid_i && !full;
  assign s_ready_o = !full;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= s_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] tcnt;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      xn_o      <= '0;
      stf_o     <= 1'b0;
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      busy_o    <= 1'b0;
      count_o   <= 16'd0;
`ifdef SEQ_TIMEOUT_EN
      timeout_o <= 1'b0;
      tcnt      <= '0;
`endif
    end else begin
      stf_o <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      timeout_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!empty) begin
            xn_o   <= mem[rd_ptr[AW-1:0]];
            rd_ptr <= rd_ptr + PTR_ONE;
            busy_o <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          stf_o <= 1'b1;
          state <= START;
        end
        START: begin
`ifdef SEQ_TIMEOUT_EN
          tcnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          // eof on the expiry cycle still completes normally.
          if (eof_i) begin
            m_data_o  <= y_i;
            m_valid_o <= 1'b1;
            count_o   <= count_o + 16'd1;
            state     <= OUT;
`ifdef SEQ_TIMEOUT_EN
          end else if (tcnt == TW'(TIMEOUT-1)) begin
            timeout_o <= 1'b1;
            busy_o    <= 1'b0;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
`endif
          end
        end
        OUT: begin
          if (m_ready_i) begin
            m_valid_o <= 1'b0;
            busy_o    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_stream_driver.sv
// ============================================================================
// Module   : tb_fir_stream_driver
// Purpose  : Randomized self-checking bench with a behavioural filter core
//            (eof ~21 cycles after stf, y = xn) and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_stream_driver;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        s_valid_i = 1'b0;
  logic [17:0] s_data_i = '0;
  logic        s_ready_o;
  logic        stf_o;
  logic [17:0] xn_o;
  logic [17:0] y_i;
  logic        eof_i;
  logic        m_valid_o;
  logic [17:0] m_data_o;
  logic        m_ready_i;
  logic        busy_o;
  logic [15:0] count_o;
  logic        timeout_o;

  logic        man_ready = 1'b1;
  logic        rnd_ready = 1'b0;
  logic        rnd_bit   = 1'b1;
  logic        man_eof   = 1'b0;
  logic        core_en   = 1'b1;
  logic        core_eof  = 1'b0;
  logic [17:0] core_x    = '0;
  int          core_cnt  = 0;

  int          vectors = 0;
  int          miscompares = 0;
  int          stf_cnt = 0;
  int          n_res = 0;
  int          to_cnt = 0;
  logic [17:0] exp_q[$];

  assign m_ready_i = rnd_ready ? rnd_bit : man_ready;
  assign eof_i     = core_eof | man_eof;
  assign y_i       = core_x;

  always #5 clk_i = ~clk_i;

  fir_stream_driver dut (
    .clk_i(clk_i), .rst_i(rst_i), .s_valid_i(s_valid_i), .s_data_i(s_data_i),
    .s_ready_o(s_ready_o), .stf_o(stf_o), .xn_o(xn_o), .y_i(y_i), .eof_i(eof_i),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_ready_i(m_ready_i),
    .busy_o(busy_o), .count_o(count_o), .timeout_o(timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Filter core stand-in: one result per start, y equals the sample.
  always @(posedge clk_i) begin
    if (stf_o && core_en) begin
      core_cnt <= 21;
      core_x   <= xn_o;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
    end
    core_eof <= (core_cnt == 1);
  end

  always @(negedge clk_i) begin
    if (rnd_ready) rnd_bit = 1'($urandom_range(0, 1));
  end

  // Scoreboard: predicts each handshake that the coming rising edge will take.
  always @(negedge clk_i) begin
    #1;
    if (rst_i) begin
      exp_q.delete();
    end else begin
      if (s_valid_i && s_ready_o) exp_q.push_back(s_data_i);
      if (stf_o) stf_cnt++;
      if (timeout_o) begin
        to_cnt++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) chk("extra_result", 32'd1, 32'd0);
        else begin
          chk("m_data", 32'(m_data_o), 32'(exp_q.pop_front()));
          n_res++;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    s_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    stf_cnt = 0;
    n_res = 0;
  endtask

  task automatic send(input logic [17:0] d);
    bit done = 0;
    @(negedge clk_i);
    s_valid_i = 1'b1;
    s_data_i  = d;
    for (int t = 0; t < 3000 && !done; t++) begin
      #1;
      if (s_ready_o) begin
        @(posedge clk_i);
        #1 s_valid_i = 1'b0;
        done = 1;
      end else begin
        @(negedge clk_i);
      end
    end
    if (!done) begin
      chk("send_timeout", 32'd0, 32'd1);
      s_valid_i = 1'b0;
    end
  endtask

  task automatic drain(input int lim);
    bit done = 0;
    for (int t = 0; t < lim && !done; t++) begin
      @(negedge clk_i);
      #2;
      if (exp_q.size() == 0 && !busy_o && !m_valid_o) done = 1;
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  int k_stf, k_to, seen;

  initial begin
    // 1: reset values
    do_reset();
    #1;
    chk("rst_s_ready", 32'(s_ready_o), 32'd1);
    chk("rst_stf", 32'(stf_o), 32'd0);
    chk("rst_xn", 32'(xn_o), 32'd0);
    chk("rst_m_valid", 32'(m_valid_o), 32'd0);
    chk("rst_m_data", 32'(m_data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);

    // 2: single sample, start pulse two edges after the push
    man_ready = 1'b1;
    send(18'h08000);
    k_stf = -1;
    for (int k = 0; k < 10 && k_stf < 0; k++) begin
      @(negedge clk_i);
      if (stf_o) k_stf = k;
    end
    chk("stf_latency", 32'(k_stf), 32'd2);
    seen = 0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk_i);
      #1;
      if (m_valid_o) begin
        seen = 1;
        chk("single_data", 32'(m_data_o), 32'h08000);
      end
    end
    chk("single_seen", 32'(seen), 32'd1);
    drain(200);
    chk("single_stf_cnt", 32'(stf_cnt), 32'd1);
    chk("single_count", 32'(count_o), 32'd1);

    // 3: burst of six with downstream stalled
    do_reset();
    man_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(18'(18'h100 + 18'(i) * 18'h111));
    @(negedge clk_i);
    #1 chk("burst_full", 32'(s_ready_o), 32'd0);
    man_ready = 1'b1;
    send(18'h2ABCD);
    drain(2000);
    chk("burst_results", 32'(n_res), 32'd6);
    chk("burst_count", 32'(count_o), 32'd6);

    // 4: eof while idle is ignored
    @(negedge clk_i);
    man_eof = 1'b1;
    @(negedge clk_i);
    man_eof = 1'b0;
    seen = 0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk_i);
      #1 if (m_valid_o) seen = 1;
    end
    chk("idle_eof_mv", 32'(seen), 32'd0);
    chk("idle_eof_count", 32'(count_o), 32'd6);

    // 5: reset during WAIT flushes everything
    do_reset();
    man_ready = 1'b1;
    send(18'h01234);
    send(18'h05678);
    for (int t = 0; t < 20 && !stf_o; t++) @(negedge clk_i);
    repeat (5) @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("wrst_stf", 32'(stf_o), 32'd0);
    chk("wrst_s_ready", 32'(s_ready_o), 32'd1);
    seen = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk_i);
      #1 if (m_valid_o || busy_o) seen = 1;
    end
    chk("wrst_quiet", 32'(seen), 32'd0);
    chk("wrst_count", 32'(count_o), 32'd0);

    // Randomized traffic with random downstream backpressure
    do_reset();
    rnd_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      send(18'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk_i);
    end
    drain(5000);
    rnd_ready = 1'b0;
    chk("rand_results", 32'(n_res), 32'd24);
    chk("rand_count", 32'(count_o), 32'd24);
    chk("no_timeout", 32'(to_cnt), 32'd0);

`ifdef SEQ_TIMEOUT_EN
    // 6: core never answers -> abort 64 cycles after WAIT entry
    do_reset();
    core_en = 1'b0;
    send(18'h00777);
    k_stf = -1;
    k_to  = -1;
    seen  = 0;
    for (int k = 0; k < 200 && k_to < 0; k++) begin
      @(negedge clk_i);
      #1;
      if (stf_o && k_stf < 0) k_stf = k;
      if (timeout_o) k_to = k;
      if (m_valid_o) seen = 1;
    end
    chk("to_latency", 32'(k_to - k_stf), 32'd65);
    chk("to_no_result", 32'(seen), 32'd0);
    chk("to_count", 32'(count_o), 32'd0);
    core_en = 1'b1;
    send(18'h3FFFF);
    drain(500);
    chk("to_recover_res", 32'(n_res), 32'd1);
    chk("to_recover_count", 32'(count_o), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
